boule_rouge_spawner: RTL and testbench

//  Drives the red-ball sprite layer: picks start cube, 6-move path and respawn delay from a 16-bit LFSR, issues
//  e_enable_br / e_move_br / e_XY0_br, then tracks the ball via done_move_br / br_end. Publishes the cube under the

---
 rtl/boule_rouge_spawner.sv | 234 +++++++++++++++++++++++
 tb/tb_boule_rouge_spawner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boule_rouge_spawner.sv
// boule_rouge_spawner
//   Red-ball spawner. A 16-bit Galois LFSR picks the respawn delay, the start
//   side and the 6-move path. The block requests a ball from the ball layer,
//   then follows its landings and publishes the cube under the ball as a
//   one-hot mask (bit0 = top cube).
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   e_start_qb          restart request, honoured while paused
//   e_pause_qb          pause request
//   e_resume_qb         resume request (wins over start)
//   freeze_power        spawn-delay counter holds while high
//   KO_qb               Q*bert hit: stop tracking the current ball
//   done_move_br        level from ball layer, rises on each landing
//   br_end              level from ball layer, rises when the ball has faded
//   e_enable_br         spawn request, held until the first landing
//   e_move_br[5:0]      path bits, bit k-1 steers move k (1: col+1)
//   e_XY0_br[20:0]      start cube pixel origin {x[20:10], y[9:0]}
//   br_cube[31:0]       one-hot cube under the ball, 0 when none
//   br_row[2:0]         current row (7 = fallen off)
//   br_active           ball alive and on the pyramid
//   br_spawn_cnt[7:0]   spawns issued, saturating
module boule_rouge_spawner #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [31:0] DELAY_MIN   = 32'd25_000_000,
  parameter logic [4:0]  DELAY_SHIFT = 5'd16,
  parameter logic [20:0] XY_LEFT     = 21'h0,
  parameter logic [20:0] XY_RIGHT    = 21'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_start_qb,
  input  logic        e_pause_qb,
  input  logic        e_resume_qb,
  input  logic        freeze_power,
  input  logic        KO_qb,
  input  logic        done_move_br,
  input  logic        br_end,
  output logic        e_enable_br,
  output logic [5:0]  e_move_br,
  output logic [20:0] e_XY0_br,
  output logic [31:0] br_cube,
  output logic [2:0]  br_row,
  output logic        br_active,
  output logic [7:0]  br_spawn_cnt
);

  typedef enum logic [1:0] {G_RESUME, G_PAUSE, G_RESTART} game_t;
  typedef enum logic [1:0] {S_WAIT, S_SPAWN, S_TRACK, S_ENDW} state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [31:0] delay_of(input logic [15:0] v);
    delay_of = DELAY_MIN + ({24'd0, v[7:0]} << DELAY_SHIFT);
  endfunction

  // Row r starts at triangular index r*(r+1)/2.
  function automatic logic [31:0] cube_of(input logic [2:0] row, input logic [2:0] col);
    logic [4:0] base;
    case (row)
      3'd0:    base = 5'd0;
      3'd1:    base = 5'd1;
      3'd2:    base = 5'd3;
      3'd3:    base = 5'd6;
      3'd4:    base = 5'd10;
      3'd5:    base = 5'd15;
      3'd6:    base = 5'd21;
      default: base = 5'd28;
    endcase
    cube_of = 32'd1 << (base + {2'b00, col});
  endfunction

  game_t       game_q, game_d;
  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] delay_q, delay_d;
  logic        dm_prev_q, dm_prev_d;
  logic        end_prev_q, end_prev_d;
  logic        enable_q, enable_d;
  logic [5:0]  move_q, move_d;
  logic [20:0] xy_q, xy_d;
  logic        side_q, side_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  land_q, land_d;
  logic        active_q, active_d;
  logic [31:0] cube_q, cube_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dm_rise, end_rise;

  always_comb begin
    game_d     = game_q;
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    delay_d    = delay_q;
    dm_prev_d  = done_move_br;
    end_prev_d = br_end;
    enable_d   = enable_q;
    move_d     = move_q;
    xy_d       = xy_q;
    side_d     = side_q;
    row_d      = row_q;
    col_d      = col_q;
    land_d     = land_q;
    active_d   = active_q;
    cnt_d      = cnt_q;
    dm_rise    = done_move_br & ~dm_prev_q;
    end_rise   = br_end & ~end_prev_q;

    case (game_q)
      G_RESUME:  if (e_pause_qb) game_d = G_PAUSE;
      G_PAUSE: begin
        if (e_resume_qb)     game_d = G_RESUME;
        else if (e_start_qb) game_d = G_RESTART;
      end
      default:   game_d = G_RESUME;
    endcase

    if (game_q == G_RESUME) begin
      lfsr_d = lfsr_step(lfsr_q);
      case (state_q)
        S_WAIT: begin
          if (!freeze_power) begin
            // Spawn on the cycle the count would reach zero.
            if (delay_q <= 32'd1) begin
              move_d   = lfsr_q[13:8];
              side_d   = lfsr_q[14];
              xy_d     = lfsr_q[14] ? XY_RIGHT : XY_LEFT;
              enable_d = 1'b1;
              state_d  = S_SPAWN;
            end else begin
              delay_d = delay_q - 32'd1;
            end
          end
        end
        S_SPAWN: begin
          if (KO_qb) begin
            enable_d = 1'b0;
            state_d  = S_ENDW;
          end else if (dm_rise) begin
            enable_d = 1'b0;
            row_d    = 3'd1;
            col_d    = {2'b00, side_q};
            land_d   = 3'd0;
            active_d = 1'b1;
            cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            state_d  = S_TRACK;
          end
        end
        S_TRACK: begin
          if (KO_qb) begin
            active_d = 1'b0;
            state_d  = S_ENDW;
          end else if (dm_rise) begin
            land_d = land_q + 3'd1;
            row_d  = row_q + 3'd1;
            col_d  = col_q + {2'b00, move_q[land_q]};
            if (row_q == 3'd6) begin
              active_d = 1'b0;
              state_d  = S_ENDW;
            end
          end
        end
        default: begin
          if (end_rise) begin
            delay_d = delay_of(lfsr_q);
            state_d = S_WAIT;
          end
        end
      endcase
    end else if (game_q == G_RESTART) begin
      enable_d = 1'b0;
      move_d   = '0;
      xy_d     = '0;
      side_d   = 1'b0;
      row_d    = '0;
      col_d    = '0;
      land_d   = '0;
      active_d = 1'b0;
      delay_d  = delay_of(lfsr_q);
      state_d  = S_WAIT;
    end

    cube_d = active_d ? cube_of(row_d, col_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      game_q     <= G_RESUME;
      state_q    <= S_WAIT;
      lfsr_q     <= LFSR_SEED;
      delay_q    <= delay_of(LFSR_SEED);
      dm_prev_q  <= 1'b0;
      end_prev_q <= 1'b0;
      enable_q   <= 1'b0;
      move_q     <= '0;
      xy_q       <= '0;
      side_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      land_q     <= '0;
      active_q   <= 1'b0;
      cube_q     <= '0;
      cnt_q      <= '0;
    end else begin
      game_q     <= game_d;
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      delay_q    <= delay_d;
      dm_prev_q  <= dm_prev_d;
      end_prev_q <= end_prev_d;
      enable_q   <= enable_d;
      move_q     <= move_d;
      xy_q       <= xy_d;
      side_q     <= side_d;
      row_q      <= row_d;
      col_q      <= col_d;
      land_q     <= land_d;
      active_q   <= active_d;
      cube_q     <= cube_d;
      cnt_q      <= cnt_d;
    end
  end

  assign e_enable_br  = enable_q;
  assign e_move_br    = move_q;
  assign e_XY0_br     = xy_q;
  assign br_cube      = cube_q;
  assign br_row       = row_q;
  assign br_active    = active_q;
  assign br_spawn_cnt = cnt_q;

endmodule

// File: tb/tb_boule_rouge_spawner.sv
// Bench for boule_rouge_spawner: directed stimulus pushes expected output
// vectors (with the cycle they must appear on) into a queue; a monitor pops
// and compares on every change of the DUT outputs.
module tb_boule_rouge_spawner;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [31:0] DMIN = 32'd4;
  localparam logic [20:0] XYL  = 21'h0A0B0;
  localparam logic [20:0] XYR  = 21'h1F00F;

  logic clk = 1'b0;
  logic reset, e_start_qb, e_pause_qb, e_resume_qb, freeze_power, KO_qb;
  logic done_move_br, br_end;
  logic        e_enable_br;
  logic [5:0]  e_move_br;
  logic [20:0] e_XY0_br;
  logic [31:0] br_cube;
  logic [2:0]  br_row;
  logic        br_active;
  logic [7:0]  br_spawn_cnt;

  boule_rouge_spawner #(
    .LFSR_SEED(SEED), .DELAY_MIN(DMIN), .DELAY_SHIFT(5'd0),
    .XY_LEFT(XYL), .XY_RIGHT(XYR)
  ) dut (
    .clk(clk), .reset(reset), .e_start_qb(e_start_qb), .e_pause_qb(e_pause_qb),
    .e_resume_qb(e_resume_qb), .freeze_power(freeze_power), .KO_qb(KO_qb),
    .done_move_br(done_move_br), .br_end(br_end), .e_enable_br(e_enable_br),
    .e_move_br(e_move_br), .e_XY0_br(e_XY0_br), .br_cube(br_cube), .br_row(br_row),
    .br_active(br_active), .br_spawn_cnt(br_spawn_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [71:0] v; int at; } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check_vec(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
  endtask

  logic [71:0] outv;
  assign outv = {e_enable_br, e_move_br, e_XY0_br, br_cube, br_row, br_active, br_spawn_cnt};

  bit mon_en = 1'b0;
  logic [71:0] prev = '0;
  always @(negedge clk) begin
    if (mon_en && (outv !== prev)) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_change @cyc %0d: got %h was %h", cyc, outv, prev);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_vec("outputs", outv, e.v);
        check_int("event_cycle", cyc, e.at);
      end
      prev = outv;
    end
  end

  // Reference model state
  int E0, p_edges, m_land;
  logic [5:0]  m_move;
  logic        m_side, m_en, m_act;
  logic [20:0] m_xy;
  logic [2:0]  m_row, m_col;
  logic [31:0] m_cube;
  logic [7:0]  m_cnt;

  function automatic logic [15:0] lfsr_n(input int n);
    logic [15:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // LFSR value held after edge e (p_edges = paused edges up to e).
  function automatic logic [15:0] lfsr_after(input int e);
    return lfsr_n(e - E0 - p_edges);
  endfunction

  function automatic logic [31:0] cube_at(input logic act, input int row, input int col);
    if (!act) return 32'd0;
    return 32'd1 << (row * (row + 1) / 2 + col);
  endfunction

  function automatic logic [71:0] mvec();
    return {m_en, m_move, m_xy, m_cube, m_row, m_act, m_cnt};
  endfunction

  task automatic push(input int at);
    exp_t e;
    e.v = mvec();
    e.at = at;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic plan_spawn(input int s);
    logic [15:0] l;
    l = lfsr_after(s - 1);
    m_move = l[13:8];
    m_side = l[14];
    m_xy   = l[14] ? XYR : XYL;
    m_en   = 1'b1;
    push(s);
  endtask

  task automatic land(input bit ko);
    if (ko) begin
      m_act = 1'b0;
    end else if (m_en) begin
      m_en = 1'b0; m_row = 3'd1; m_col = {2'b00, m_side}; m_land = 0; m_act = 1'b1;
      m_cnt = (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
    end else begin
      m_col = m_col + {2'b00, m_move[m_land]};
      m_land++;
      m_row = m_row + 3'd1;
      if (m_row == 3'd7) m_act = 1'b0;
    end
    m_cube = cube_at(m_act, int'(m_row), int'(m_col));
    push(cyc + 1);
    done_move_br = 1'b1; KO_qb = ko;
    step(1);
    done_move_br = 1'b0; KO_qb = 1'b0;
    step(1);
  endtask

  task automatic end_pulse(output int x);
    br_end = 1'b1;
    step(1);
    x = cyc;
    step(1);
    br_end = 1'b0;
  endtask

  initial begin
    int x, n, c, d;
    logic [15:0] l;
    reset = 1'b1; e_start_qb = 0; e_pause_qb = 0; e_resume_qb = 0;
    freeze_power = 0; KO_qb = 0; done_move_br = 0; br_end = 0;
    m_move = '0; m_side = 0; m_en = 0; m_act = 0; m_xy = '0; m_row = '0;
    m_col = '0; m_cube = '0; m_cnt = '0; m_land = 0;
    step(3);
    check_vec("reset_state", outv, 72'd0);
    reset = 1'b0;
    E0 = cyc; p_edges = 0;
    mon_en = 1'b1;

    // First spawn after DELAY_MIN + seed[7:0], then a full 7-landing descent.
    l = SEED;
    n = int'(DMIN) + int'(l[7:0]);
    plan_spawn(E0 + n);
    wait_until(E0 + n + 1);
    repeat (7) land(1'b0);
    end_pulse(x);

    // Pause in WAIT with 10 cycles left, 50 paused edges.
    l = lfsr_after(x - 1);
    n = int'(DMIN) + int'(l[7:0]);
    c = (x + n - 11 > cyc) ? x + n - 11 : cyc;
    wait_until(c);
    e_pause_qb = 1'b1;
    step(1);
    e_pause_qb = 1'b0;
    p_edges += 50;
    plan_spawn(x + n + 50);
    wait_until(c + 50);
    e_resume_qb = 1'b1;
    step(1);
    e_resume_qb = 1'b0;
    wait_until(x + n + 51);
    repeat (3) land(1'b0);
    land(1'b1);                 // KO together with a landing at row 3
    done_move_br = 1'b1; step(1); done_move_br = 1'b0; step(1);
    end_pulse(x);

    // Freeze for 20 cycles in WAIT.
    l = lfsr_after(x - 1);
    n = int'(DMIN) + int'(l[7:0]);
    plan_spawn(x + n + 20);
    freeze_power = 1'b1;
    step(20);
    freeze_power = 1'b0;
    wait_until(x + n + 21);
    land(1'b0);

    // Pause then restart: outputs clear, spawn count kept.
    c = cyc;
    e_pause_qb = 1'b1;
    step(1);
    e_pause_qb = 1'b0;
    step(3);
    d = cyc;
    m_en = 0; m_move = '0; m_xy = '0; m_cube = '0; m_row = '0; m_act = 0;
    push(d + 2);
    e_start_qb = 1'b1;
    step(1);
    e_start_qb = 1'b0;
    step(1);
    p_edges += d - c + 1;
    x = d + 2;

    // Spawn after restart, then KO while waiting for the first landing.
    l = lfsr_after(x);
    n = int'(DMIN) + int'(l[7:0]);
    plan_spawn(x + n);
    wait_until(x + n + 1);
    m_en = 1'b0;
    push(cyc + 1);
    KO_qb = 1'b1;
    step(1);
    KO_qb = 1'b0;
    step(1);
    end_pulse(x);

    // Reset mid-operation clears everything, including the spawn count.
    m_move = '0; m_xy = '0; m_cnt = '0;
    push(cyc + 1);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(5);
    check_int("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
